program_loader: RTL and testbench

- Boot-time writer for main memory; fills the write port of main_memory, which the core itself never drives.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive word addresses and holds the CPU in reset until loading completes.
- Sits between an external byte source (UART/debug bridge) and main_memory's write_address/write_data/write_enable; its cpu_hold output gates the CPU reset.

---
 rtl/loader_pkg.sv | 29 ++
 rtl/word_assembler.sv | 59 +++++
 rtl/program_loader.sv | 164 ++++++++++++++++
 tb/tb_program_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Combinational only: no latency, no flow control.
// Defines the loader FSM states and the byte/word geometry of the input stream.
//
// Contents:
//   BYTES_PER_WORD  bytes per assembled memory word (count word and data words)
//   LOADER_BYTE_W   width of one stream byte
//   LOADER_WORD_W   width of one assembled word
//   state_e         loader FSM states
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LOADER_BYTE_W  = 8;
    localparam int LOADER_WORD_W  = BYTES_PER_WORD * LOADER_BYTE_W;

    // COUNT : collecting the 4-byte word count
    // DATA  : collecting the 4 bytes of the next data word
    // WRITE : single-cycle memory write strobe, input back-pressured
    // DONE  : load finished, CPU released, terminal until reset
    // ERROR : word count larger than the memory, terminal until reset
    typedef enum logic [2:0] {
        COUNT = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

endpackage : loader_pkg

// File: rtl/word_assembler.sv
// Packs a byte stream into little-endian 32-bit words.
// Latency: word/word_valid are combinational with the strobe of the 4th byte.
// Backpressure: none; the caller only strobes bytes it has actually accepted.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   byte_stb    one accepted byte this cycle
//   byte_dat    accepted byte payload
//   clear       drop any partial word and restart at byte 0
//   word        assembled word, including the byte being strobed this cycle
//   word_valid  one-cycle pulse on the strobe that completes a word
module word_assembler
    import loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_stb,
    input  logic [LOADER_BYTE_W-1:0] byte_dat,
    input  logic                     clear,
    output logic [LOADER_WORD_W-1:0] word,
    output logic                     word_valid
);

    logic [1:0]               byte_idx_q;
    logic [1:0]               byte_idx_d;
    logic [LOADER_WORD_W-1:0] asm_q;
    logic [LOADER_WORD_W-1:0] asm_d;

    // The byte being strobed is merged combinationally so the completed word
    // is available in the same cycle its last byte is accepted; this is what
    // lets the loader enter WRITE on that very edge.
    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        if (clear) begin
            byte_idx_d = 2'd0;
            asm_d      = '0;
        end else if (byte_stb) begin
            asm_d[int'(byte_idx_q) * LOADER_BYTE_W +: LOADER_BYTE_W] = byte_dat;
            // 2-bit index wraps 3 -> 0 naturally at the end of each word.
            byte_idx_d = byte_idx_q + 2'd1;
        end
    end

    assign word       = asm_d;
    assign word_valid = byte_stb && !clear && (byte_idx_q == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end

endmodule : word_assembler

// File: rtl/program_loader.sv
// Boot-time loader: byte stream -> word count + little-endian words -> main memory.
// Latency: write_enable rises in the cycle right after the edge accepting a word's 4th byte.
// Backpressure: in_ready drops for the single WRITE cycle and permanently in DONE/ERROR.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   in_valid       source presents a byte
//   in_data        byte payload
//   in_ready       loader accepts a byte this cycle (COUNT or DATA)
//   write_address  memory word address (base_addr + word index)
//   write_data     memory write data
//   write_enable   one-cycle write strobe
//   cpu_hold       1 keeps the CPU in reset; low only once loading is done
//   done           load complete
//   error          word count exceeded depth
module program_loader
    import loader_pkg::*;
#(
    parameter int          depth     = 2048,
    parameter logic [31:0] base_addr = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        write_enable,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] DEPTH_W = 32'(depth);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] word_idx_q;
    logic [31:0] word_idx_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic [31:0] waddr_q;
    logic [31:0] waddr_d;
    logic [31:0] wdata_q;
    logic [31:0] wdata_d;

    logic                     byte_stb;
    logic                     asm_clear;
    logic [LOADER_WORD_W-1:0] asm_word;
    logic                     asm_vld;

    // A byte transfer happens only on an accepting cycle; in_data is
    // otherwise ignored.
    assign byte_stb  = in_valid && in_ready;
    // Terminal states keep the assembler empty so nothing stale survives.
    assign asm_clear = (state_q == DONE) || (state_q == ERROR);

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst        (rst),
        .byte_stb   (byte_stb),
        .byte_dat   (in_data),
        .clear      (asm_clear),
        .word       (asm_word),
        .word_valid (asm_vld)
    );

    // ------------------------------------------------------------------
    // State register (plus the datapath registers it steers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COUNT;
            word_idx_q <= '0;
            count_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            COUNT: begin
                if (asm_vld) begin
                    count_d    = asm_word;
                    word_idx_d = '0;
                    if (asm_word == 32'd0) begin
                        state_d = DONE;
                    end else if (asm_word > DEPTH_W) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Address and data are captured on the accepting edge so they
                // are already stable while WRITE asserts the strobe; they then
                // hold until the next word completes.
                if (asm_vld) begin
                    wdata_d = asm_word;
                    waddr_d = base_addr + word_idx_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 32'd1;
                state_d    = (word_idx_d == count_q) ? DONE : DATA;
            end
            DONE: begin
                state_d = DONE;
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        write_enable = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        unique case (state_q)
            COUNT:   in_ready     = 1'b1;
            DATA:    in_ready     = 1'b1;
            WRITE:   write_enable = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERROR:   error        = 1'b1;
            default: error        = 1'b1;
        endcase
    end

    assign write_address = waddr_q;
    assign write_data    = wdata_q;

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// Two instances share the stimulus: base_addr 0 and base_addr 0x100.
// Writes are collected by negedge monitors and compared to hand-computed values.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready_a, we_a, hold_a, done_a, err_a;
    logic [31:0] addr_a, data_a;
    logic        in_ready_b, we_b, hold_b, done_b, err_b;
    logic [31:0] addr_b, data_b;

    program_loader #(.depth(2048), .base_addr(32'h0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .write_address(addr_a), .write_data(data_a),
        .write_enable(we_a), .cpu_hold(hold_a), .done(done_a), .error(err_a)
    );

    program_loader #(.depth(2048), .base_addr(32'h100)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .write_address(addr_b), .write_data(data_b),
        .write_enable(we_b), .cpu_hold(hold_b), .done(done_b), .error(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [31:0] qb_addr[$];
    logic [31:0] qb_data[$];
    int          we_runs = 0;
    logic        we_a_prev = 1'b0;
    int          waits[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Write collectors; a strobe seen on two consecutive negedges is a run.
    always @(negedge clk) begin
        if (we_a) begin
            qa_addr.push_back(addr_a);
            qa_data.push_back(data_a);
            if (we_a_prev) we_runs++;
        end
        we_a_prev = we_a;
        if (we_b) begin
            qb_addr.push_back(addr_b);
            qb_data.push_back(data_b);
        end
    end

    task automatic clear_log();
        qa_addr.delete(); qa_data.delete();
        qb_addr.delete(); qb_data.delete();
        waits.delete();
        we_runs = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte; keeps in_valid high until accepted. Returns at posedge+1.
    task automatic send_byte(input logic [7:0] b, output int w);
        w        = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready_a) break;
            w++;
            if (w > 20) begin
                check_eq("send_rdy_timeout", 32'(in_ready_a), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Send a byte sequence; max_gap>0 inserts random idle cycles, except
    // after index no_gap_idx so in_valid stays high across the WRITE cycle.
    task automatic send_seq(input logic [7:0] s[$], input int max_gap, input int no_gap_idx);
        int w;
        int g;
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], w);
            waits.push_back(w);
            g = (max_gap > 0 && i != no_gap_idx) ? int'($urandom_range(max_gap, 0)) : 0;
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    // Hold in_valid high for n cycles regardless of in_ready.
    task automatic drive_raw(input logic [7:0] b, input int n);
        in_valid = 1'b1;
        in_data  = b;
        repeat (n) @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_two_writes(input string tag);
        check_eq({tag, "_nwr"}, 32'(qa_addr.size()), 32'd2);
        if (qa_addr.size() == 2) begin
            check_eq({tag, "_addr0"}, qa_addr[0], 32'h0);
            check_eq({tag, "_data0"}, qa_data[0], 32'h1234_5678);
            check_eq({tag, "_addr1"}, qa_addr[1], 32'h1);
            check_eq({tag, "_data1"}, qa_data[1], 32'hDEAD_BEEF);
        end
        check_eq({tag, "_we_runs"}, 32'(we_runs), 32'd0);
        check_eq({tag, "_done"}, 32'(done_a), 32'd1);
        check_eq({tag, "_hold"}, 32'(hold_a), 32'd0);
        check_eq({tag, "_rdy"}, 32'(in_ready_a), 32'd0);
        // First byte of the second data word must stall exactly one WRITE cycle.
        if (waits.size() == 12) check_eq({tag, "_stall8"}, 32'(waits[8]), 32'd1);
        else check_eq({tag, "_nbytes"}, 32'(waits.size()), 32'd12);
    endtask

    logic [7:0] seq[$];

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        // Reset state
        check_eq("rst_rdy",  32'(in_ready_a), 32'd1);
        check_eq("rst_hold", 32'(hold_a), 32'd1);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_err",  32'(err_a), 32'd0);
        check_eq("rst_we",   32'(we_a), 32'd0);
        check_eq("rst_addr", addr_a, 32'h0);
        check_eq("rst_data", data_a, 32'h0);

        // 1: two words back-to-back
        do_reset();
        seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(seq, 0, -1);
        repeat (3) @(negedge clk);
        check_two_writes("t1");
        if (waits.size() == 12) check_eq("t1_stall4", 32'(waits[4]), 32'd0);

        // 2: zero-length load
        do_reset();
        seq = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(seq, 0, -1);
        check_eq("t2_done", 32'(done_a), 32'd1);
        check_eq("t2_hold", 32'(hold_a), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t2_nwr", 32'(qa_addr.size()), 32'd0);

        // 3: count 2049 > depth
        do_reset();
        seq = '{8'h01, 8'h08, 8'h00, 8'h00};
        send_seq(seq, 0, -1);
        check_eq("t3_err",  32'(err_a), 32'd1);
        check_eq("t3_rdy",  32'(in_ready_a), 32'd0);
        check_eq("t3_hold", 32'(hold_a), 32'd1);
        check_eq("t3_done", 32'(done_a), 32'd0);
        drive_raw(8'hFF, 6);
        repeat (2) @(negedge clk);
        check_eq("t3_err_after", 32'(err_a), 32'd1);
        check_eq("t3_nwr", 32'(qa_addr.size()), 32'd0);

        // 4: same stream with random gaps, in_valid held through WRITE
        do_reset();
        seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(seq, 3, 7);
        repeat (3) @(negedge clk);
        check_two_writes("t4");

        // 5: reset in the middle of the second word
        do_reset();
        seq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_seq(seq, 0, -1);
        @(negedge clk);
        check_eq("t5_pre_nwr",  32'(qa_addr.size()), 32'd1);
        check_eq("t5_pre_data", data_a, 32'h4433_2211);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t5_rst_we",   32'(we_a), 32'd0);
        check_eq("t5_rst_addr", addr_a, 32'h0);
        check_eq("t5_rst_data", data_a, 32'h0);
        check_eq("t5_rst_rdy",  32'(in_ready_a), 32'd1);
        check_eq("t5_rst_hold", 32'(hold_a), 32'd1);
        check_eq("t5_rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        @(posedge clk);
        #1;
        seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        send_seq(seq, 0, -1);
        repeat (3) @(negedge clk);
        check_eq("t5_nwr", 32'(qa_addr.size()), 32'd1);
        if (qa_addr.size() == 1) begin
            check_eq("t5_addr", qa_addr[0], 32'h0);
            check_eq("t5_data", qa_data[0], 32'hA5A5_A5A5);
        end
        check_eq("t5_done", 32'(done_a), 32'd1);

        // 6: base_addr 0x100 on instance b
        do_reset();
        seq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        send_seq(seq, 0, -1);
        repeat (3) @(negedge clk);
        check_eq("t6_nwr", 32'(qb_addr.size()), 32'd1);
        if (qb_addr.size() == 1) begin
            check_eq("t6_addr", qb_addr[0], 32'h100);
            check_eq("t6_data", qb_data[0], 32'h1122_3344);
        end
        if (qa_addr.size() == 1) check_eq("t6_addr_base0", qa_addr[0], 32'h0);
        check_eq("t6_done", 32'(done_b), 32'd1);
        drive_raw(8'h99, 5);
        repeat (2) @(negedge clk);
        check_eq("t6_nwr_after",  32'(qb_addr.size()), 32'd1);
        check_eq("t6_done_after", 32'(done_b), 32'd1);
        check_eq("t6_hold_after", 32'(hold_b), 32'd0);
        check_eq("t6_rdy_after",  32'(in_ready_b), 32'd0);
        check_eq("t6_addr_held",  addr_b, 32'h100);
        check_eq("t6_data_held",  data_b, 32'h1122_3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule : tb_program_loader
